// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer sharing one full-adder cell, LSB first
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN.

module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             y_bit;
  logic             fa_s;
  logic             fa_c;
  logic             cin_load;
  logic [WIDTH-1:0] sum_next;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  // Subtraction is a + ~b + 1: invert every y bit and force the initial carry.
  assign y_bit    = b_sh[0] ^ sub_q;
  assign cin_load = in_sub ? 1'b1 : in_cin;
`else
  assign y_bit    = b_sh[0];
  assign cin_load = in_cin;
`endif

  serial_adder_fa u_fa (
    .x    (a_sh[0]),
    .y    (y_bit),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New sum bit enters at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
  assign sum_next = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= in_a;
            b_sh     <= in_b;
            carry    <= cin_load;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SERIAL_ADD_SUB_EN
            sub_q    <= in_sub;
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_sum   <= sum_next;
            out_cout  <= fa_c;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - table-driven bench with scoreboard for serial_adder_ctrl
// Subtract vectors run when SERIAL_ADD_SUB_EN is defined.

module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } vec_t;

  vec_t        vecs[6];
  logic [WIDTH:0] sb_q[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair, check latency, then pop the scoreboard and compare the result.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                        input string name);
    int t;
    logic [WIDTH:0] e;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin step(); t++; end
    check({name, " accept_timeout"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    sb_q.push_back({exp_cout, exp_sum});
    t = 0;
    while (!out_valid && t < 100) begin step(); t++; end
    check({name, " latency"}, 32'(t), 32'(WIDTH));
    check({name, " busy_done"}, {31'd0, busy}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, " sum"}, 32'(out_sum), 32'(e[WIDTH-1:0]));
      check({name, " cout"}, {31'd0, out_cout}, {31'd0, e[WIDTH]});
    end else begin
      check({name, " scoreboard_empty"}, 32'd0, 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({name, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    int               seen;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sub: 1'b0, sum: 8'h96, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, sub: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: 1'b0, sum: 8'hFF, cout: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sub: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sub: 1'b0, sum: 8'h01, cout: 1'b0};
    vecs[5] = '{a: 8'hA5, b: 8'h0F, cin: 1'b0, sub: 1'b0, sum: 8'hB4, cout: 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    step(); step();
    rst = 1'b0;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_sum", 32'(out_sum), 32'd0);
    check("reset out_cout", {31'd0, out_cout}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].sum, vecs[i].cout,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
      r = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      run_op(ra, rb, rc, 1'b0, r[WIDTH-1:0], r[WIDTH], $sformatf("rand%0d", i));
    end

    // Backpressure: offers during RUN/DONE are ignored, result holds while out_ready is low.
    in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    step();
    in_a = 8'hAA; in_b = 8'h55;
    seen = 0;
    while (!out_valid && seen < 100) begin
      check("bp in_ready_run", {31'd0, in_ready}, 32'd0);
      step(); seen++;
    end
    check("bp latency", 32'(seen), 32'(WIDTH));
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid_hold", {31'd0, out_valid}, 32'd1);
      check("bp sum_hold", 32'(out_sum), 32'h46);
      check("bp cout_hold", {31'd0, out_cout}, 32'd0);
      check("bp in_ready_done", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp back_idle", {31'd0, in_ready}, 32'd1);
    run_op(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, "bp next");

    // Reset with the bit counter at 3 discards the partial result.
    in_a = 8'h77; in_b = 8'h11; in_cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst out_sum", 32'(out_sum), 32'd0);
    check("midrst out_cout", {31'd0, out_cout}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      step();
    end
    check("midrst no_result", 32'(seen), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, "after_rst");

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub1");
    run_op(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, "sub2");
    run_op(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, "sub_cin_ignored");
    run_op(8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0, "add_after_sub");
`endif

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
